riscv_dual_port_mem: RTL and testbench
======================================

# riscv_dual_port_mem

Word-organised memory that answers the CPU core's two memory ports: a read-only instruction port, and a read/write load/store port with wait-state support. It sits directly beside the core in the lab top level and in its testbench, holding program and data in one shared array. Instruction reads have a fixed 1-cycle latency with no stall. Load/store accesses go through a small handshake FSM that inserts a programmable number of wait states through `o_ldst_waitrequest`.

## Interface
- `IW`, 32, data/address width in bits
- `DEPTH_WORDS`, 8192, number of 32-bit words; must be a power of 2; `AW = $clog2(DEPTH_WORDS)`
- `LDST_WAIT`, 2, wait-state cycles added to every load/store access (0..15)
- `INIT_FILE`, "", hex image loaded with `$readmemh` at elaboration when non-empty

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `i_pc_addr`  in  IW  instruction byte address
- `i_pc_rd`  in  1  instruction read strobe
- `i_pc_byte_en`  in  4  accepted but ignored; full word is always returned
- `o_pc_rddata`  out  IW  instruction word, registered
- `i_ldst_addr`  in  IW  load/store byte address
- `i_ldst_rd`  in  1  read request
- `i_ldst_wr`  in  1  write request
- `i_ldst_wrdata`  in  IW  write data, lane-aligned
- `i_ldst_byte_en`  in  4  write lane enables; bit n selects bits [8n+7:8n]
- `o_ldst_rddata`  out  IW  read word, registered
- `o_ldst_waitrequest`  out  1  stall; the requester holds its request while this is high

## Operation
- Word index is `addr[AW+1:2]`.
  - `addr[1:0]` and the bits above `AW+1` are ignored, so out-of-range addresses alias (wrap).
- The array is not cleared by reset. Its contents are X, or come from `INIT_FILE`.
- Instruction port:
  - On each rising edge with `i_pc_rd=1`, `o_pc_rddata` takes `mem[index]`.
  - With `i_pc_rd=0`, `o_pc_rddata` holds its value.
- Load/store FSM has three states: IDLE, BUSY, ACK.
  - IDLE:
    - If `i_ldst_wr` or `i_ldst_rd` is high, latch the operation and clear the wait counter.
    - If `LDST_WAIT==0`, go to ACK; otherwise go to BUSY.
  - BUSY:
    - The counter increments each cycle.
    - When the counter reaches `LDST_WAIT-1`, go to ACK.
    - A read samples `mem[index]` into `o_ldst_rddata` on the BUSY→ACK edge. For `LDST_WAIT==0` the sample happens on the IDLE→ACK edge.
  - ACK:
    - `o_ldst_waitrequest` is low.
    - A write commits the enabled lanes at the end of the ACK cycle.
    - Always return to IDLE.
- `o_ldst_waitrequest` is combinational:
  - 1 while `reset` is high.
  - In IDLE, it equals `i_ldst_rd | i_ldst_wr`.
  - 1 in BUSY; 0 in ACK.
- Simultaneous `i_ldst_rd` and `i_ldst_wr` is treated as a write, and `o_ldst_rddata` is unchanged.
- Request dropped while in BUSY: the access is abandoned and the FSM returns to IDLE next edge. No write occurs and read data is not updated.
- Address, data and enables are sampled from the live inputs in the cycle of the commit or sample. The protocol requires them to be held stable.
- Write byte enable `4'b0000` completes the handshake and changes nothing.
- Collision:
  - An instruction read and a load/store write to the same word on the same edge: the instruction read returns the old data (read-before-write).
  - A load/store read following a write completes with the new data.

## Timing
- Reset values:
  - `o_pc_rddata=0`, `o_ldst_rddata=0`, FSM=IDLE, counter=0.
  - `o_ldst_waitrequest=1` during reset.
- Instruction read latency: 1 cycle. The address is presented in cycle N and the data is valid in cycle N+1. Back-to-back reads give 1 word per cycle.
- Load/store access is `LDST_WAIT+2` cycles from the first request cycle to the first cycle after ACK.
  - `o_ldst_waitrequest` is high for the first `LDST_WAIT+1` of those cycles and low for exactly one cycle (ACK).
- A new request may be presented in the cycle after ACK. Maximum throughput is 1 access per `LDST_WAIT+2` cycles.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the pending write is dropped.

## Test plan
- Preload `mem[0..3]` = `0x00500093`, `0x00A00113`, `0x002081B3`, `0x0000006F`. Assert `i_pc_rd` with addresses 0, 4, 8, 12 on consecutive cycles. Required: `o_pc_rddata` equals those four words one cycle later each, with no gaps.
- `LDST_WAIT=2`: write `0xDEADBEEF` to `0x100` with byte_en `4'b1111`, then read `0x100`. Required:
  - waitrequest is high for 3 cycles and low for 1 on each access.
  - Read returns `0xDEADBEEF` in its ACK cycle.
- Byte-lane write: `mem[0x40>>2]=0x11223344`; write `0xAABBCCDD` with byte_en `4'b0101`. Required: a read returns `0x11BB33DD`.
- Collision: `mem[0x20>>2]=0x1`. The load/store write of `0x2` commits on the same edge as an instruction read of `0x20`. Required: `o_pc_rddata=0x1`, and the next instruction read gives `0x2`.
- Abandon and reset: start a write of `0x55` to `0x80` (`LDST_WAIT=3`) and drop `i_ldst_wr` in BUSY. Separately, assert `reset` mid-BUSY on a second write. Required:
  - `mem[0x80>>2]` is unchanged in both cases.
  - After reset, `o_ldst_rddata=0`, `o_pc_rddata=0`, and the FSM is in IDLE.
- Aliasing and `LDST_WAIT=0`: write `0x77` to `0x0` with `DEPTH_WORDS=16`, then read `0x40`. Required:
  - The read returns `0x77`.
  - waitrequest is high exactly 1 cycle per access.

Source files
------------

// File: rtl/riscv_dual_port_mem.sv
// riscv_dual_port_mem: shared program/data word memory with a 1-cycle instruction
// port and a load/store port that stretches each access by LDST_WAIT wait states.
module riscv_dual_port_mem #(
    parameter int    IW          = 32,
    parameter int    DEPTH_WORDS = 8192,
    parameter int    LDST_WAIT   = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] i_pc_addr,
    input  logic          i_pc_rd,
    input  logic [3:0]    i_pc_byte_en,
    output logic [IW-1:0] o_pc_rddata,
    input  logic [IW-1:0] i_ldst_addr,
    input  logic          i_ldst_rd,
    input  logic          i_ldst_wr,
    input  logic [IW-1:0] i_ldst_wrdata,
    input  logic [3:0]    i_ldst_byte_en,
    output logic [IW-1:0] o_ldst_rddata,
    output logic          o_ldst_waitrequest
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic [IW-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0] pc_idx;
    logic [AW-1:0] ldst_idx;
    logic          req;
    logic          last_wait;
    logic          sample;
    logic          unused_bits;

    assign pc_idx    = i_pc_addr[AW+1:2];
    assign ldst_idx  = i_ldst_addr[AW+1:2];
    assign req       = i_ldst_rd | i_ldst_wr;
    assign last_wait = cnt == 4'(LDST_WAIT - 1);
    // Reads sample on the edge that enters ACK; with no wait states that is the request edge.
    assign sample    = (state == IDLE && LDST_WAIT == 0 && i_ldst_rd && !i_ldst_wr)
                    || (state == BUSY && req && last_wait && !op_wr);

    assign o_ldst_waitrequest = reset || state == BUSY || (state == IDLE && req);

    assign unused_bits = ^{i_pc_byte_en, i_pc_addr[1:0], i_pc_addr[IW-1:AW+2],
                           i_ldst_addr[1:0], i_ldst_addr[IW-1:AW+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            op_wr         <= 1'b0;
            o_ldst_rddata <= '0;
        end else begin
            if (sample) o_ldst_rddata <= mem[ldst_idx];
            case (state)
                IDLE: if (req) begin
                    op_wr <= i_ldst_wr;
                    cnt   <= '0;
                    state <= LDST_WAIT == 0 ? ACK : BUSY;
                end
                BUSY: if (!req) state <= IDLE;
                      else if (last_wait) state <= ACK;
                      else cnt <= cnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_pc_rddata <= '0;
        else if (i_pc_rd) o_pc_rddata <= mem[pc_idx];
    end

    // Nonblocking write keeps a same-edge instruction read on the old word.
    always_ff @(posedge clk) begin
        if (state == ACK && op_wr)
            for (int b = 0; b < 4; b++)
                if (i_ldst_byte_en[b]) mem[ldst_idx][8*b +: 8] <= i_ldst_wrdata[8*b +: 8];
    end
endmodule

// File: tb/tb_riscv_dual_port_mem.sv
// tb_riscv_dual_port_mem: three memory instances (2, 3 and 0 wait states) driven by
// directed and random accesses, checked against a word-array model.
module tb_riscv_dual_port_mem;
    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_rd;
    logic [3:0]  pc_be;
    logic [31:0] ldst_addr [3];
    logic [31:0] wrdata    [3];
    logic        rd        [3];
    logic        wr        [3];
    logic [3:0]  be        [3];
    logic [31:0] pc_q      [3];
    logic [31:0] ld_q      [3];
    logic        wait_q    [3];

    int waits  [3] = '{2, 3, 0};
    int depths [3] = '{8192, 64, 16};
    int aws    [3] = '{13, 6, 4};

    logic [31:0] model    [3][8192];
    bit          valid    [3][8192];
    logic [31:0] ld_model [3];
    logic [31:0] prog     [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

    int n_checks = 0;
    int n_fail   = 0;

    riscv_dual_port_mem #(.LDST_WAIT(2), .DEPTH_WORDS(8192)) u_w2 (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .i_pc_byte_en(pc_be), .o_pc_rddata(pc_q[0]),
        .i_ldst_addr(ldst_addr[0]), .i_ldst_rd(rd[0]), .i_ldst_wr(wr[0]),
        .i_ldst_wrdata(wrdata[0]), .i_ldst_byte_en(be[0]),
        .o_ldst_rddata(ld_q[0]), .o_ldst_waitrequest(wait_q[0]));

    riscv_dual_port_mem #(.LDST_WAIT(3), .DEPTH_WORDS(64)) u_w3 (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .i_pc_byte_en(pc_be), .o_pc_rddata(pc_q[1]),
        .i_ldst_addr(ldst_addr[1]), .i_ldst_rd(rd[1]), .i_ldst_wr(wr[1]),
        .i_ldst_wrdata(wrdata[1]), .i_ldst_byte_en(be[1]),
        .o_ldst_rddata(ld_q[1]), .o_ldst_waitrequest(wait_q[1]));

    riscv_dual_port_mem #(.LDST_WAIT(0), .DEPTH_WORDS(16)) u_w0 (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .i_pc_byte_en(pc_be), .o_pc_rddata(pc_q[2]),
        .i_ldst_addr(ldst_addr[2]), .i_ldst_rd(rd[2]), .i_ldst_wr(wr[2]),
        .i_ldst_wrdata(wrdata[2]), .i_ldst_byte_en(be[2]),
        .o_ldst_rddata(ld_q[2]), .o_ldst_waitrequest(wait_q[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_for(input int k, input int idx);
        return ($urandom << (aws[k] + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // One complete handshake on instance k, entered and left just after a rising edge.
    task automatic access(input int k, input bit do_rd, input bit do_wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit coll);
        int hi;
        bit acked;
        int idx;
        logic [31:0] old;
        idx = int'((a >> 2) % 32'(depths[k]));
        ldst_addr[k] = a;
        wrdata[k]    = d;
        be[k]        = b;
        rd[k]        = do_rd;
        wr[k]        = do_wr;
        hi    = 0;
        acked = 0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(negedge clk);
            if (wait_q[k]) hi++;
            else acked = 1;
            if (!acked) begin
                @(posedge clk);
                #1;
            end
        end
        check("ldst_ack_seen", 32'(acked), 32'd1);
        check("ldst_wait_cycles", 32'(hi), 32'(waits[k] + 1));
        if (do_rd && !do_wr) ld_model[k] = model[k][idx];
        check("ldst_rddata", ld_q[k], ld_model[k]);
        if (coll) begin
            pc_addr = a;
            pc_rd   = 1'b1;
        end
        old = model[k][idx];
        @(posedge clk);
        #1;
        if (do_wr) begin
            for (int l = 0; l < 4; l++)
                if (b[l]) model[k][idx][8*l +: 8] = d[8*l +: 8];
            if (b == 4'hF) valid[k][idx] = 1'b1;
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        if (coll) begin
            check("collision_old", pc_q[k], old);
            @(posedge clk);
            #1;
            check("collision_new", pc_q[k], model[k][idx]);
            pc_rd = 1'b0;
        end
    endtask

    initial begin
        int k;
        int idx;
        int op;
        logic [3:0] b;
        logic [31:0] a;
        reset   = 1'b0;
        pc_addr = '0;
        pc_rd   = 1'b0;
        pc_be   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            ldst_addr[i] = '0;
            wrdata[i]    = '0;
            rd[i]        = 1'b0;
            wr[i]        = 1'b0;
            be[i]        = 4'h0;
            ld_model[i]  = '0;
        end
        #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_pc_rddata", pc_q[i], 32'h0);
            check("reset_ldst_rddata", ld_q[i], 32'h0);
            check("reset_waitrequest", 32'(wait_q[i]), 32'd1);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) access(0, 0, 1, 32'(i * 4), prog[i], 4'hF, 0);
        pc_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_addr = 32'(i * 4);
            @(posedge clk);
            #1;
            check("pc_stream", pc_q[0], prog[i]);
        end
        pc_rd   = 1'b0;
        pc_addr = 32'h0;
        @(posedge clk);
        #1;
        check("pc_hold", pc_q[0], prog[3]);

        access(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
        access(0, 1, 0, 32'h100, 32'h0, 4'h0, 0);
        check("deadbeef_read", ld_q[0], 32'hDEADBEEF);

        access(0, 0, 1, 32'h40, 32'h11223344, 4'hF, 0);
        access(0, 0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, 0);
        access(0, 1, 0, 32'h40, 32'h0, 4'h0, 0);
        check("byte_lane_read", ld_q[0], 32'h11BB33DD);
        access(0, 1, 1, 32'h100, 32'h0, 4'h0, 0);
        check("rdwr_is_write_keeps_rddata", ld_q[0], 32'h11BB33DD);

        access(0, 0, 1, 32'h20, 32'h1, 4'hF, 0);
        access(0, 0, 1, 32'h20, 32'h2, 4'hF, 1);

        access(2, 0, 1, 32'h0, 32'h77, 4'hF, 0);
        access(2, 1, 0, 32'h40, 32'h0, 4'h0, 0);
        check("alias_read", ld_q[2], 32'h77);

        access(1, 0, 1, 32'h80, 32'h12345678, 4'hF, 0);
        ldst_addr[1] = 32'h80;
        wrdata[1]    = 32'h55;
        be[1]        = 4'hF;
        wr[1]        = 1'b1;
        @(posedge clk);
        #1;
        check("abandon_busy_wait", 32'(wait_q[1]), 32'd1);
        wr[1] = 1'b0;
        @(posedge clk);
        #1;
        check("abandon_idle_wait", 32'(wait_q[1]), 32'd0);
        check("abandon_rddata", ld_q[1], ld_model[1]);
        access(1, 1, 0, 32'h80, 32'h0, 4'h0, 0);
        check("abandon_mem", ld_q[1], 32'h12345678);

        wrdata[1] = 32'h66;
        wr[1]     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        wr[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midreset_ldst_rddata", ld_q[i], 32'h0);
            check("midreset_pc_rddata", pc_q[i], 32'h0);
            ld_model[i] = '0;
        end
        check("midreset_wait", 32'(wait_q[1]), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("after_reset_idle", 32'(wait_q[1]), 32'd0);
        @(posedge clk);
        #1;
        access(1, 1, 0, 32'h80, 32'h0, 4'h0, 0);
        check("reset_dropped_write", ld_q[1], 32'h12345678);

        repeat (60) begin
            k   = $urandom_range(0, 2);
            idx = $urandom_range(0, 15);
            a   = addr_for(k, idx);
            op  = $urandom_range(0, 2);
            b   = 4'($urandom_range(0, 15));
            if (!valid[k][idx]) begin
                op = 1;
                b  = 4'hF;
            end
            access(k, op != 1, op != 0, a, $urandom, b, 0);
        end

        pc_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc_addr = 32'(i << 2);
            @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++)
                if (valid[j][i]) check("pc_sweep", pc_q[j], model[j][i]);
        end
        pc_rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
